// File: rtl/servant_mem_arbiter_if.sv
// Bus bundle for servant_mem_arbiter: both master ports plus the shared memory slave port.
// The slave modport is the arbiter's own view; the master modport is the surrounding system.
interface servant_mem_arbiter_if;
    logic [31:0] i_m0_adr;
    logic [31:0] i_m0_dat;
    logic        i_m0_we;
    logic        i_m0_cyc;
    logic [31:0] o_m0_rdt;
    logic        o_m0_ack;

    logic [31:0] i_m1_adr;
    logic [31:0] i_m1_dat;
    logic        i_m1_we;
    logic        i_m1_cyc;
    logic [31:0] o_m1_rdt;
    logic        o_m1_ack;

    logic [31:0] o_s_adr;
    logic [31:0] o_s_dat;
    logic        o_s_we;
    logic        o_s_cyc;
    logic [31:0] i_s_rdt;
    logic        i_s_ack;

    modport slave (
        input  i_m0_adr, i_m0_dat, i_m0_we, i_m0_cyc,
        output o_m0_rdt, o_m0_ack,
        input  i_m1_adr, i_m1_dat, i_m1_we, i_m1_cyc,
        output o_m1_rdt, o_m1_ack,
        output o_s_adr, o_s_dat, o_s_we, o_s_cyc,
        input  i_s_rdt, i_s_ack
    );

    modport master (
        output i_m0_adr, i_m0_dat, i_m0_we, i_m0_cyc,
        input  o_m0_rdt, o_m0_ack,
        output i_m1_adr, i_m1_dat, i_m1_we, i_m1_cyc,
        input  o_m1_rdt, o_m1_ack,
        input  o_s_adr, o_s_dat, o_s_we, o_s_cyc,
        output i_s_rdt, i_s_ack
    );
endinterface

// File: rtl/servant_mem_arbiter.sv
// Round-robin two-master Wishbone arbiter for the servant data memory port, one idle slave cycle per transaction.
// Define ARB_TIMEOUT_EN to add a TIMEOUT_CYCLES slave-cycle budget with forced completion (rdt 32'hDEADBEEF).
module servant_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                  i_wb_clk,
    input  logic                  i_wb_rst_n,
    servant_mem_arbiter_if.slave  bus,
    output logic [1:0]            o_grant,
    output logic                  o_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  grant;
    logic [1:0]  served;
    logic        last;

    logic [1:0]  req;
    logic [1:0]  avail;
    logic        busy;
    logic        own_cyc;
    logic        done;
    logic        abort;
    logic        expire;
    logic        ack_any;
    logic [31:0] rdt;

    assign req     = {bus.i_m1_cyc, bus.i_m0_cyc};
    // The master served (or aborted) just before RECOVER is masked there.
    assign avail   = req & ~served;
    assign busy    = (state == BUSY);
    assign own_cyc = |(grant & req);
    assign done    = busy & bus.i_s_ack;
    assign abort   = busy & ~own_cyc & ~bus.i_s_ack;
    assign ack_any = done | expire;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt;

    // A real ack in the expiry cycle takes priority over the forced completion.
    assign expire = busy & own_cyc & ~bus.i_s_ack & (cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= '0;
        end
    end
`else
    logic unused_cfg;

    assign expire     = 1'b0;
    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

    assign bus.o_s_adr  = grant[1] ? bus.i_m1_adr : bus.i_m0_adr;
    assign bus.o_s_dat  = grant[1] ? bus.i_m1_dat : bus.i_m0_dat;
    assign bus.o_s_we   = grant[1] ? bus.i_m1_we  : bus.i_m0_we;
    assign bus.o_s_cyc  = busy & own_cyc;

    assign rdt          = expire ? 32'hDEADBEEF : bus.i_s_rdt;
    assign bus.o_m0_rdt = rdt;
    assign bus.o_m1_rdt = rdt;
    assign bus.o_m0_ack = ack_any & grant[0];
    assign bus.o_m1_ack = ack_any & grant[1];

    assign o_grant      = grant;
    assign o_timeout    = expire;

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            served <= '0;
            last   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= BUSY;
                        if (&req) begin
                            grant <= last ? 2'b01 : 2'b10;
                        end else begin
                            grant <= req;
                        end
                    end
                end
                BUSY: begin
                    if (ack_any) begin
                        last   <= grant[1];
                        served <= grant;
                        grant  <= '0;
                        state  <= RECOVER;
                    end else if (abort) begin
                        served <= grant;
                        grant  <= '0;
                        state  <= RECOVER;
                    end
                end
                RECOVER: begin
                    if (|avail) begin
                        grant <= avail;
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servant_mem_arbiter.sv
// Directed bench for servant_mem_arbiter against a 3-edge-latency memory slave model.
// Timeout expectations follow ARB_TIMEOUT_EN when it is defined for the build.
module tb_servant_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;

    servant_mem_arbiter_if bus ();

    servant_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .bus        (bus),
        .o_grant    (grant),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Memory slave: acks once cyc has been high for 3 edges; contents preset to 32'h1111_00ii.
    logic        slave_mute = 1'b0;
    logic        mem_ready = 1'b0;
    int          scnt = 0;
    logic [31:0] mem [16];

    assign bus.i_s_ack = bus.o_s_cyc && (scnt >= 3) && !slave_mute;
    assign bus.i_s_rdt = mem[bus.o_s_adr[5:2]];

    always @(posedge clk) begin
        if (!bus.o_s_cyc || bus.i_s_ack) scnt <= 0;
        else                             scnt <= scnt + 1;
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1111_0000 + 32'(i);
            mem_ready <= 1'b1;
        end else if (bus.i_s_ack && bus.o_s_we) begin
            mem[bus.o_s_adr[5:2]] <= bus.o_s_dat;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_m0_adr = '0; bus.i_m0_dat = '0; bus.i_m0_we = 1'b0; bus.i_m0_cyc = 1'b0;
        bus.i_m1_adr = '0; bus.i_m1_dat = '0; bus.i_m1_we = 1'b0; bus.i_m1_cyc = 1'b0;

        // Reset state
        tick(2);
        chk("rst_s_cyc", 32'(bus.o_s_cyc), 0);
        chk("rst_m0_ack", 32'(bus.o_m0_ack), 0);
        chk("rst_m1_ack", 32'(bus.o_m1_ack), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst_n = 1'b1;

        // T1: m0 write alone, request appears in cycle 0
        tick(1);
        bus.i_m0_cyc = 1'b1; bus.i_m0_we = 1'b1; bus.i_m0_adr = 32'h10; bus.i_m0_dat = 32'hA5;
        #1;
        chk("t1_c0_s_cyc", 32'(bus.o_s_cyc), 0);
        chk("t1_c0_grant", 32'(grant), 0);
        tick(1);
        chk("t1_c1_s_cyc", 32'(bus.o_s_cyc), 1);
        chk("t1_c1_grant", 32'(grant), 32'b01);
        chk("t1_c1_s_adr", bus.o_s_adr, 32'h10);
        chk("t1_c1_s_dat", bus.o_s_dat, 32'hA5);
        chk("t1_c1_s_we", 32'(bus.o_s_we), 1);
        chk("t1_c1_m0_ack", 32'(bus.o_m0_ack), 0);
        tick(2);
        chk("t1_c3_m0_ack", 32'(bus.o_m0_ack), 0);
        tick(1);
        chk("t1_c4_m0_ack", 32'(bus.o_m0_ack), 1);
        chk("t1_c4_m1_ack", 32'(bus.o_m1_ack), 0);
        tick(1);
        bus.i_m0_cyc = 1'b0; bus.i_m0_we = 1'b0;
        #1;
        chk("t1_c5_s_cyc", 32'(bus.o_s_cyc), 0);
        chk("t1_c5_grant", 32'(grant), 0);
        chk("t1_c5_m0_ack", 32'(bus.o_m0_ack), 0);
        tick(1);

        // T2: simultaneous reads right after reset, first tie goes to m0
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        bus.i_m0_cyc = 1'b1; bus.i_m0_adr = 32'h10;
        bus.i_m1_cyc = 1'b1; bus.i_m1_adr = 32'h20;
        #1;
        tick(1);
        chk("t2_c1_grant", 32'(grant), 32'b01);
        chk("t2_c1_s_adr", bus.o_s_adr, 32'h10);
        tick(3);
        chk("t2_c4_m0_ack", 32'(bus.o_m0_ack), 1);
        chk("t2_c4_m0_rdt", bus.o_m0_rdt, 32'hA5);
        tick(1);
        bus.i_m0_cyc = 1'b0;
        #1;
        chk("t2_c5_s_cyc", 32'(bus.o_s_cyc), 0);
        chk("t2_c5_grant", 32'(grant), 0);
        chk("t2_c5_m1_ack", 32'(bus.o_m1_ack), 0);
        tick(1);
        chk("t2_c6_grant", 32'(grant), 32'b10);
        chk("t2_c6_s_cyc", 32'(bus.o_s_cyc), 1);
        chk("t2_c6_s_adr", bus.o_s_adr, 32'h20);
        tick(2);
        chk("t2_c8_m1_ack", 32'(bus.o_m1_ack), 0);
        tick(1);
        chk("t2_c9_m1_ack", 32'(bus.o_m1_ack), 1);
        chk("t2_c9_m1_rdt", bus.o_m1_rdt, 32'h1111_0008);
        chk("t2_c9_m0_ack", 32'(bus.o_m0_ack), 0);
        tick(1);
        bus.i_m1_cyc = 1'b0;
        #1;
        tick(1);

        // T3: m0 keeps requesting, m1 requests once; last = m1 so m0 wins the tie
        bus.i_m0_cyc = 1'b1; bus.i_m0_adr = 32'h20;
        bus.i_m1_cyc = 1'b1; bus.i_m1_adr = 32'h10;
        #1;
        tick(1);
        chk("t3_c1_grant", 32'(grant), 32'b01);
        tick(3);
        chk("t3_c4_m0_ack", 32'(bus.o_m0_ack), 1);
        tick(1);
        bus.i_m0_cyc = 1'b0;
        #1;
        tick(1);
        bus.i_m0_cyc = 1'b1;
        #1;
        chk("t3_c6_grant", 32'(grant), 32'b10);
        tick(3);
        chk("t3_c9_m1_ack", 32'(bus.o_m1_ack), 1);
        chk("t3_c9_m0_ack", 32'(bus.o_m0_ack), 0);
        tick(1);
        bus.i_m1_cyc = 1'b0;
        #1;
        tick(1);
        chk("t3_c11_grant", 32'(grant), 32'b01);
        tick(3);
        chk("t3_c14_m0_ack", 32'(bus.o_m0_ack), 1);
        tick(1);
        bus.i_m0_cyc = 1'b0;
        #1;
        tick(1);

        // T4: m1 aborts two cycles into BUSY; last stays m0 so the next tie goes to m1
        bus.i_m1_cyc = 1'b1; bus.i_m1_adr = 32'h20;
        #1;
        tick(1);
        chk("t4_c1_grant", 32'(grant), 32'b10);
        tick(2);
        bus.i_m1_cyc = 1'b0;
        #1;
        chk("t4_c3_s_cyc", 32'(bus.o_s_cyc), 0);
        chk("t4_c3_m1_ack", 32'(bus.o_m1_ack), 0);
        tick(1);
        chk("t4_c4_grant", 32'(grant), 0);
        chk("t4_c4_m1_ack", 32'(bus.o_m1_ack), 0);
        tick(1);
        chk("t4_c5_grant", 32'(grant), 0);
        bus.i_m0_cyc = 1'b1; bus.i_m0_adr = 32'h10;
        bus.i_m1_cyc = 1'b1;
        #1;
        tick(1);
        chk("t4_c6_tie_grant", 32'(grant), 32'b10);
        tick(3);
        chk("t4_c9_m1_ack", 32'(bus.o_m1_ack), 1);
        tick(1);
        bus.i_m1_cyc = 1'b0;
        #1;
        tick(1);
        chk("t4_c11_grant", 32'(grant), 32'b01);
        tick(3);
        chk("t4_c14_m0_ack", 32'(bus.o_m0_ack), 1);
        tick(1);
        bus.i_m0_cyc = 1'b0;
        #1;
        tick(1);

        // T5: reset pulse mid-BUSY, then a fresh m1 read
        bus.i_m0_cyc = 1'b1; bus.i_m0_adr = 32'h10;
        #1;
        tick(1);
        chk("t5_c1_grant", 32'(grant), 32'b01);
        tick(1);
        rst_n = 1'b0;
        #1;
        tick(1);
        rst_n = 1'b1;
        bus.i_m0_cyc = 1'b0;
        bus.i_m1_cyc = 1'b1; bus.i_m1_adr = 32'h10;
        #1;
        chk("t5_c3_s_cyc", 32'(bus.o_s_cyc), 0);
        chk("t5_c3_grant", 32'(grant), 0);
        chk("t5_c3_m0_ack", 32'(bus.o_m0_ack), 0);
        chk("t5_c3_m1_ack", 32'(bus.o_m1_ack), 0);
        tick(1);
        chk("t5_c4_grant", 32'(grant), 32'b10);
        chk("t5_c4_s_cyc", 32'(bus.o_s_cyc), 1);
        tick(3);
        chk("t5_c7_m1_ack", 32'(bus.o_m1_ack), 1);
        chk("t5_c7_m1_rdt", bus.o_m1_rdt, 32'hA5);
        tick(1);
        bus.i_m1_cyc = 1'b0;
        #1;
        tick(1);

        // T6: slave never acks m0; m1 queues behind it
        slave_mute = 1'b1;
        bus.i_m0_cyc = 1'b1; bus.i_m0_adr = 32'h20;
        #1;
        tick(1);
        bus.i_m1_cyc = 1'b1; bus.i_m1_adr = 32'h10;
        #1;
        chk("t6_c1_grant", 32'(grant), 32'b01);
        tick(6);
        chk("t6_c7_m0_ack", 32'(bus.o_m0_ack), 0);
        chk("t6_c7_timeout", 32'(timeout), 0);
        tick(1);
`ifdef ARB_TIMEOUT_EN
        chk("t6_c8_m0_ack", 32'(bus.o_m0_ack), 1);
        chk("t6_c8_m0_rdt", bus.o_m0_rdt, 32'hDEADBEEF);
        chk("t6_c8_timeout", 32'(timeout), 1);
        chk("t6_c8_m1_ack", 32'(bus.o_m1_ack), 0);
        tick(1);
        bus.i_m0_cyc = 1'b0;
        slave_mute = 1'b0;
        #1;
        chk("t6_c9_timeout", 32'(timeout), 0);
        chk("t6_c9_grant", 32'(grant), 0);
        chk("t6_c9_s_cyc", 32'(bus.o_s_cyc), 0);
        tick(1);
        chk("t6_c10_grant", 32'(grant), 32'b10);
        tick(3);
        chk("t6_c13_m1_ack", 32'(bus.o_m1_ack), 1);
        chk("t6_c13_m1_rdt", bus.o_m1_rdt, 32'hA5);
        chk("t6_c13_timeout", 32'(timeout), 0);
        tick(1);
        bus.i_m1_cyc = 1'b0;
        #1;
`else
        chk("t6_c8_m0_ack", 32'(bus.o_m0_ack), 0);
        chk("t6_c8_timeout", 32'(timeout), 0);
        tick(12);
        chk("t6_c20_grant", 32'(grant), 32'b01);
        chk("t6_c20_s_cyc", 32'(bus.o_s_cyc), 1);
        chk("t6_c20_m0_ack", 32'(bus.o_m0_ack), 0);
        chk("t6_c20_timeout", 32'(timeout), 0);
        tick(1);
        slave_mute = 1'b0;
        #1;
        chk("t6_c21_m0_ack", 32'(bus.o_m0_ack), 1);
        chk("t6_c21_m0_rdt", bus.o_m0_rdt, 32'h1111_0008);
        tick(1);
        bus.i_m0_cyc = 1'b0;
        #1;
        tick(1);
        chk("t6_c23_grant", 32'(grant), 32'b10);
        tick(3);
        chk("t6_c26_m1_ack", 32'(bus.o_m1_ack), 1);
        chk("t6_c26_m1_rdt", bus.o_m1_rdt, 32'hA5);
        tick(1);
        bus.i_m1_cyc = 1'b0;
        #1;
`endif
        tick(2);
        chk("end_grant", 32'(grant), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
